// File: rtl/div_iter_unit.sv
// Iterative restoring divider for EX-stage DIV/DIVU; {rem, quo} result for HI/LO.
// Optional macro DIV_FAST_ZERO_EN: divide-by-zero short-cut through the ZERO state.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   start_i, signed_i      request (held by EX), 1 = DIV / 0 = DIVU
//   dividend_i, divisor_i  rs / rt operands, sampled with start_i
//   annul_i                flush; drops the in-flight divide
//   result_o               {remainder, quotient}, valid while ready_o
//   ready_o                one-cycle result pulse
//   stall_o                combinational pipeline stall request
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    ON,
    END
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sgn_a_q;
  logic             sgn_b_q;
  logic             is_signed_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             zero_div;

  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept   = (state_q == IDLE) & start_i & ~annul_i;
  assign a_neg    = signed_i & dividend_i[WIDTH-1];
  assign b_neg    = signed_i & divisor_i[WIDTH-1];
  assign a_mag    = a_neg ? -dividend_i : dividend_i;
  assign b_mag    = b_neg ? -divisor_i : divisor_i;
  assign zero_div = (divisor_i == '0);

  // Trial is one bit wider than the operands so large unsigned
  // divisors never lose the shifted-out remainder msb.
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign take   = ~trial[WIDTH];
  assign rem_nx = take ? trial[WIDTH-1:0] : rem_sh;
  assign quo_nx = {quo_q[WIDTH-2:0], take};
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  // Truncating division: quotient sign is the xor of operand
  // signs, remainder follows the dividend.
  assign neg_q = is_signed_q & (sgn_a_q ^ sgn_b_q);
  assign neg_r = is_signed_q & sgn_a_q;
  assign q_fix = neg_q ? -quo_nx : quo_nx;
  assign r_fix = neg_r ? -rem_nx : rem_nx;

  assign stall_o = (state_q == ON) | (state_q == ZERO) | accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sgn_a_q     <= 1'b0;
      sgn_b_q     <= 1'b0;
      is_signed_q <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              quo_q       <= a_mag;
              dvs_q       <= b_mag;
              sgn_a_q     <= a_neg;
              sgn_b_q     <= b_neg;
              is_signed_q <= signed_i;
              rem_q       <= '0;
              cnt_q       <= '0;
              state_q     <= ON;
`ifdef DIV_FAST_ZERO_EN
              // Raw dividend parks in rem_q for the ZERO result.
              if (zero_div) begin
                rem_q   <= dividend_i;
                state_q <= ZERO;
              end
`else
              if (zero_div) begin
                state_q <= ON;
              end
`endif
            end
          end
          ZERO: begin
            result_o <= {rem_q, {WIDTH{1'b1}}};
            ready_o  <= 1'b1;
            state_q  <= END;
          end
          ON: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
              state_q  <= END;
            end
          end
          END: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit.
// Directed DIV/DIVU vectors, annul, reset and back-to-back cases.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] last_res = '0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ready_o) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 64'(ready_o), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_res"}, result_o, e.res);
        check({e.name, "_lat"}, 64'(cyc), 64'(e.at));
        check({e.name, "_stall_rdy"}, 64'(stall_o), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(string nm, bit sgn, logic [31:0] a,
                       logic [31:0] b, logic [63:0] exp, bit track);
    int lat;
    lat = 33;
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'd0) lat = 2;
`endif
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    #1;
    check({nm, "_stall_req"}, 64'(stall_o), 64'd1);
    if (track) begin
      sb.push_back('{exp, cyc + lat, nm});
      last_res = exp;
    end
    tick();
    start_i    = 1'b0;
    signed_i   = ~sgn;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i  = 32'h0000_0001;
    check({nm, "_stall_busy"}, 64'(stall_o), 64'd1);
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    resetn = 1'b1;
    tick();

    issue("div_100_7", 1, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
    wait_done(40);
    issue("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2,
          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
    wait_done(40);
    issue("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF,
          {32'h0, 32'h8000_0000}, 1);
    wait_done(40);
    issue("div_7_m2", 1, 32'd7, 32'hFFFF_FFFE,
          {32'd1, 32'hFFFF_FFFD}, 1);
    wait_done(40);
    issue("div_m100_m7", 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          {32'hFFFF_FFFE, 32'd14}, 1);
    wait_done(40);
    issue("divu_big", 0, 32'hFFFF_FFFF, 32'h8000_0001,
          {32'h7FFF_FFFE, 32'd1}, 1);
    wait_done(40);
    issue("divu_max_2", 0, 32'hFFFF_FFFF, 32'd2,
          {32'd1, 32'h7FFF_FFFF}, 1);
    wait_done(40);
    issue("divu_b2b", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 1);
    wait_done(40);

    issue("annul", 1, 32'd100, 32'd7, 64'd0, 0);
    repeat (9) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_stall", 64'(stall_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_hold", result_o, last_res);
    repeat (40) tick();
    check("annul_hold_late", result_o, last_res);
    start_i = 1'b1;
    annul_i = 1'b1;
    #1;
    check("annul_idle_stall", 64'(stall_o), 64'd0);
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    check("annul_idle_block", 64'(stall_o), 64'd0);
    tick();
    issue("divu_20_6", 0, 32'd20, 32'd6, {32'd2, 32'd3}, 1);
    wait_done(40);

    issue("divu_zero", 0, 32'h1234, 32'd0,
          {32'h1234, 32'hFFFF_FFFF}, 1);
    wait_done(40);

    issue("rst_mid", 0, 32'd100, 32'd7, 64'd0, 0);
    repeat (14) tick();
    resetn = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_stall", 64'(stall_o), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    issue("divu_50_5", 0, 32'd50, 32'd5, {32'd0, 32'd10}, 1);
    wait_done(40);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
